// File: rtl/uc_ctrl_if.sv
// Control interface between the datapath (master) and the control unit (slave).
// The datapath supplies the opcode and zero flag; the controller returns selects, enables and status.
interface uc_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       Opcode;
  logic             z;
  logic             s_inc;
  logic             s_inm;
  logic             we3;
  logic             wez;
  logic [2:0]       Op;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    output Opcode, z,
    input  s_inc, s_inm, we3, wez, Op, halted, illegal, instret
  );

  modport slave (
    input  Opcode, z,
    output s_inc, s_inm, we3, wez, Op, halted, illegal, instret
  );
endinterface

// File: rtl/uc_ctrl.sv
// Control unit: Mealy decode of Opcode/z into datapath controls, plus a RUN/HALTED FSM,
// a sticky illegal-opcode flag and a retired-instruction counter.
module uc_ctrl #(
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     reset,
  uc_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;

  logic             w_s_inc;
  logic             w_s_inm;
  logic             w_we3;
  logic             w_wez;
  logic [2:0]       w_op;
  logic             w_illegal_op;

  // State, sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_illegal <= 1'b0;
      r_instret <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_RUN) begin
        r_instret <= r_instret + CNT_W'(1);
      end else begin
        r_instret <= r_instret;
      end
      if (w_illegal_op) begin
        r_illegal <= 1'b1;
      end else begin
        r_illegal <= r_illegal;
      end
    end
  end

  // Next-state and Mealy control decode; reset forces every control to its inactive value
  always_comb begin
    w_next_state = r_state;
    w_s_inc      = 1'b0;
    w_s_inm      = 1'b0;
    w_we3        = 1'b0;
    w_wez        = 1'b0;
    w_op         = 3'b000;
    w_illegal_op = 1'b0;
    if (reset) begin
      w_next_state = ST_RUN;
    end else if (r_state == ST_HALTED) begin
      w_s_inc = 1'b1;
    end else begin
      casez (bus.Opcode)
        6'b1?????: begin
          w_op  = bus.Opcode[4:2];
          w_we3 = 1'b1;
          w_wez = 1'b1;
        end
        6'b01????: begin
          w_s_inm = 1'b1;
          w_we3   = 1'b1;
        end
        6'b000000: w_s_inc = 1'b0;
        6'b000001: w_s_inc = 1'b1;
        6'b000010: w_s_inc = bus.z;
        6'b000011: w_s_inc = ~bus.z;
        6'b000100: begin
          w_s_inc      = 1'b1;
          w_next_state = ST_HALTED;
        end
        // 000101..001111 retire as NOP but latch the illegal flag
        default: w_illegal_op = 1'b1;
      endcase
    end
  end

  assign bus.s_inc   = w_s_inc;
  assign bus.s_inm   = w_s_inm;
  assign bus.we3     = w_we3;
  assign bus.wez     = w_wez;
  assign bus.Op      = w_op;
  assign bus.halted  = (r_state == ST_HALTED);
  assign bus.illegal = r_illegal;
  assign bus.instret = r_instret;

endmodule

// File: tb/tb_uc_ctrl.sv
// Self-checking bench for uc_ctrl: directed test-plan steps followed by random opcodes,
// all checked against an opcode-level reference model; a CNT_W=4 instance covers counter wrap.
module tb_uc_ctrl;

  logic clk;
  logic reset;
  logic reset4;

  uc_ctrl_if #(.CNT_W(16)) bus ();
  uc_ctrl_if #(.CNT_W(4))  bus4 ();

  uc_ctrl #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  uc_ctrl #(.CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (bus4)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_halted;
  bit m_illegal;
  int m_instret;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {s_inc, s_inm, we3, wez, Op} from the instruction-set table
  function automatic logic [6:0] exp_ctrl(input int opc, input bit zz, input bit hlt);
    int op;
    if (hlt) return 7'b1000000;
    if (opc >= 32) begin
      op = (opc / 4) % 8;
      return {4'b0011, 3'(op)};
    end
    if (opc >= 16) return 7'b0110000;
    case (opc)
      1:       return 7'b1000000;
      2:       return {zz, 6'b000000};
      3:       return {!zz, 6'b000000};
      4:       return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] obs_ctrl();
    return {bus.s_inc, bus.s_inm, bus.we3, bus.wez, bus.Op};
  endfunction

  task automatic check_status(input string tag);
    check({tag, ".halted"},  32'(bus.halted),  32'(m_halted));
    check({tag, ".illegal"}, 32'(bus.illegal), 32'(m_illegal));
    check({tag, ".instret"}, 32'(bus.instret), m_instret & 32'h0000_FFFF);
  endtask

  // Present one instruction between edges, check controls, clock it, check status
  task automatic do_instr(input logic [5:0] opc, input logic zz, input string tag);
    int o;
    o = int'(opc);
    bus.Opcode = opc;
    bus.z      = zz;
    #1;
    check({tag, ".ctrl"}, 32'(obs_ctrl()), 32'(exp_ctrl(o, zz, m_halted)));
    @(posedge clk);
    if (!m_halted) begin
      m_instret++;
      if (o >= 5 && o <= 15) m_illegal = 1'b1;
      if (o == 4) m_halted = 1'b1;
    end
    #1;
    check_status(tag);
  endtask

  // Pulse reset between clock edges and check that everything clears at once
  task automatic async_reset(input string tag);
    bus.Opcode = 6'b000001;
    bus.z      = 1'b1;
    #2;
    reset = 1'b1;
    m_halted  = 1'b0;
    m_illegal = 1'b0;
    m_instret = 0;
    #1;
    check({tag, ".ctrl_in_reset"}, 32'(obs_ctrl()), 32'd0);
    check_status({tag, ".in_reset"});
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] legal_ops [5];
    reset      = 1'b1;
    reset4     = 1'b1;
    bus.Opcode = 6'b101100;
    bus.z      = 1'b1;
    bus4.Opcode = 6'b000000;
    bus4.z      = 1'b0;
    m_halted  = 1'b0;
    m_illegal = 1'b0;
    m_instret = 0;
    #16;
    check("reset.ctrl", 32'(obs_ctrl()), 32'd0);
    check_status("reset");
    reset = 1'b0;

    // NOP x3, ALU, LI, jumps
    repeat (3) do_instr(6'b000000, 1'b1, "nop");
    check("nop.instret3", 32'(bus.instret), 32'd3);
    do_instr(6'b101100, 1'b0, "alu");
    check("alu.op011", 32'(obs_ctrl()), 32'(7'b0011011));
    do_instr(6'b010000, 1'b0, "li");
    do_instr(6'b000010, 1'b1, "jz_z1");
    do_instr(6'b000010, 1'b0, "jz_z0");
    do_instr(6'b000011, 1'b1, "jnz_z1");
    do_instr(6'b000011, 1'b0, "jnz_z0");
    do_instr(6'b000001, 1'b0, "j_z0");
    do_instr(6'b000001, 1'b1, "j_z1");

    // Illegal then HALT after 5 instructions, illegal stays set
    async_reset("rst1");
    legal_ops[0] = 6'b000000;
    legal_ops[1] = 6'b110000;
    legal_ops[2] = 6'b011111;
    legal_ops[3] = 6'b000011;
    do_instr(6'b000111, 1'b0, "illegal");
    check("illegal.set", 32'(bus.illegal), 32'd1);
    for (int i = 0; i < 4; i++) do_instr(legal_ops[i], 1'(i), "post_illegal");
    do_instr(6'b000100, 1'b0, "halt");
    check("halt.instret6", 32'(bus.instret), 32'd6);
    repeat (10) do_instr(6'b101100, 1'b1, "halted");
    check("halted.frozen", 32'(bus.instret), 32'd6);
    check("halted.illegal", 32'(bus.illegal), 32'd1);

    // Async reset while halted, then NOP counts to 1
    async_reset("rst_halted");
    do_instr(6'b000000, 1'b0, "nop_after_rst");
    check("nop_after_rst.one", 32'(bus.instret), 32'd1);

    // Random opcodes, occasionally recovering from HALT
    for (int i = 0; i < 300; i++) begin
      if (m_halted && ($urandom % 4 == 0)) async_reset("rnd_rst");
      do_instr(6'($urandom_range(0, 63)), 1'($urandom), "rnd");
    end

    // 4-bit counter wrap
    reset4 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("wrap.15", 32'(bus4.instret), 32'd15);
    @(posedge clk);
    #1;
    check("wrap.16", 32'(bus4.instret), 32'd0);
    @(posedge clk);
    #1;
    check("wrap.17", 32'(bus4.instret), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
